// File: rtl/mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_seq: sequential radix-2 shift-add multiplier, signed/unsigned per op,  |
// | valid/ready on both sides.                               Revision: 1.0     |
// +----------------------------------------------------------------------------+
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   dout
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_neg;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_dout;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mplier_next;
  logic [2*WIDTH-1:0]   w_dout_next;

  // The magnitude of the most-negative operand is 2^(WIDTH-1), still fits unsigned.
  assign w_a_mag = (sgn && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
  assign w_b_mag = (sgn && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_mplier[0]) begin
      w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    end
  end

  // {carry, accumulator, multiplier} shifted right by one position.
  assign w_acc_next    = {w_sum, r_acc[WIDTH-1:1]};
  assign w_mplier_next = {r_acc[0], r_mplier[WIDTH-1:1]};
  assign w_dout_next   = r_neg ? ((2*WIDTH)'(0) - w_acc_next) : w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand    <= w_a_mag;
            r_mplier   <= w_b_mag;
            r_neg      <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc      <= '0;
            r_cnt      <= c_cnt_w'(WIDTH);
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            r_dout      <= w_dout_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// Self-checking bench for mul_seq: one WIDTH=8 and one WIDTH=16 instance checked
// every cycle against a cycle-count/arithmetic model, plus literal corner cases.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ival[2];
  logic        sg[2];
  logic        ordy[2];
  logic [15:0] ta[2];
  logic [15:0] tbv[2];

  logic        ir8, ov8, ir16, ov16;
  logic [15:0] d8;
  logic [31:0] d16;
  logic        ir_q[2];
  logic        ov_q[2];
  logic [31:0] dq[2];

  int n_checks = 0;
  int n_errors = 0;

  mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(ival[0]), .in_ready(ir8),
    .a(ta[0][7:0]), .b(tbv[0][7:0]), .sgn(sg[0]),
    .out_valid(ov8), .out_ready(ordy[0]), .dout(d8)
  );

  mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(ival[1]), .in_ready(ir16),
    .a(ta[1]), .b(tbv[1]), .sgn(sg[1]),
    .out_valid(ov16), .out_ready(ordy[1]), .dout(d16)
  );

  assign ir_q[0] = ir8;
  assign ir_q[1] = ir16;
  assign ov_q[0] = ov8;
  assign ov_q[1] = ov16;
  assign dq[0]   = {16'h0000, d8};
  assign dq[1]   = d16;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  // Reference product: plain integer a*b, interpreted per sgn, truncated to 2*w bits.
  function automatic logic [31:0] exp_prod(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic s);
    longint x, y, p, mask;
    mask = (longint'(1) << w) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (w=%0d) t=%0t: got 0x%0h, expected 0x%0h", name, wid(i), $time, act, exp);
    end
  endtask

  // Model: an accepted pair becomes visible after exactly w edges, then holds until taken.
  bit        m_busy[2];
  int        m_left[2];
  bit [31:0] m_pend[2];
  bit [31:0] m_dout[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_left[i] = 0;
        m_dout[i] = '0;
      end else if (m_busy[i] && m_left[i] == 0) begin
        if (ordy[i]) m_busy[i] = 1'b0;
      end else if (m_busy[i]) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) m_dout[i] = m_pend[i];
      end else if (ival[i]) begin
        m_busy[i] = 1'b1;
        m_left[i] = wid(i);
        m_pend[i] = exp_prod(wid(i), ta[i], tbv[i], sg[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check("in_ready", i, {31'b0, ir_q[i]}, {31'b0, !m_busy[i]});
      check("out_valid", i, {31'b0, ov_q[i]}, {31'b0, (m_busy[i] && m_left[i] == 0)});
      check("dout", i, dq[i], m_dout[i]);
    end
  end

  task automatic scramble(input int i);
    ival[i] = 1'($urandom_range(0, 1));
    ta[i]   = (i == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
    tbv[i]  = (i == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
    sg[i]   = 1'($urandom_range(0, 1));
  endtask

  // Starts #1 after an edge with the DUT idle; returns #1 after the output-accept edge.
  task automatic op(input int i, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input int stall,
                    output logic [31:0] res, output int lat);
    ival[i] = 1'b1; ta[i] = a; tbv[i] = b; sg[i] = s; ordy[i] = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    scramble(i);
    while (!ov_q[i] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      scramble(i);
    end
    if (lat >= 200) check("timeout", i, 32'(lat), 32'(wid(i)));
    res = dq[i];
    repeat (stall) begin
      @(posedge clk); #1;
      scramble(i);
    end
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
    ival[i] = 1'b0;
    check("ready_after_accept", i, {31'b0, ir_q[i]}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int          lat;
    time         t0, t1;
    logic [15:0] ra, rb;
    logic        rs;

    for (int i = 0; i < 2; i++) begin
      ival[i] = 1'b0; sg[i] = 1'b0; ordy[i] = 1'b0; ta[i] = '0; tbv[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", i, {31'b0, ir_q[i]}, 32'd1);
      check("reset_out_valid", i, {31'b0, ov_q[i]}, 32'd0);
      check("reset_dout", i, dq[i], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(0, 16'hFF, 16'hFF, 1'b0, 0, res, lat);
    check("umax", 0, res, 32'hFE01);
    check("umax_latency", 0, 32'(lat), 32'd8);
    t0 = $time;
    op(0, 16'h80, 16'h80, 1'b1, 0, res, lat);
    t1 = $time;
    check("s_min_sq", 0, res, 32'h4000);
    check("period", 0, 32'(t1 - t0), 32'd100);
    op(0, 16'hFF, 16'h7F, 1'b1, 0, res, lat);
    check("s_neg1_x_127", 0, res, 32'hFF81);
    op(0, 16'hFF, 16'h7F, 1'b0, 0, res, lat);
    check("u_255_x_127", 0, res, 32'h7E81);
    op(0, 16'h00, 16'h80, 1'b1, 0, res, lat);
    check("zero_operand", 0, res, 32'h0000);
    check("zero_latency", 0, 32'(lat), 32'd8);
    op(0, 16'h03, 16'h05, 1'b0, 5, res, lat);
    check("backpressure", 0, res, 32'h000F);

    t0 = $time;
    op(1, 16'h8000, 16'h8000, 1'b1, 0, res, lat);
    t1 = $time;
    check("w16_s_min_sq", 1, res, 32'h40000000);
    check("w16_latency", 1, 32'(lat), 32'd16);
    check("w16_period", 1, 32'(t1 - t0), 32'd180);
    op(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, res, lat);
    check("w16_umax", 1, res, 32'hFFFE0001);

    // Abort during the 4th calculation cycle.
    ival[0] = 1'b1; ta[0] = 16'h55; tbv[0] = 16'h66; sg[0] = 1'b0;
    @(posedge clk); #1;
    ival[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 0, {31'b0, ir_q[0]}, 32'd1);
    check("abort_out_valid", 0, {31'b0, ov_q[0]}, 32'd0);
    check("abort_dout", 0, dq[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(0, 16'd6, 16'd7, 1'b0, 0, res, lat);
    check("after_abort", 0, res, 32'd42);

    for (int k = 0; k < 1500; k++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      op(0, ra, rb, rs, 0, res, lat);
      check("rand8", 0, res, exp_prod(8, ra, rb, rs));
    end
    for (int k = 0; k < 1500; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      op(1, ra, rb, rs, $urandom_range(0, 3), res, lat);
      check("rand16", 1, res, exp_prod(16, ra, rb, rs));
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
